// File: rtl/br_resolve_queue_if.sv
// br_resolve_queue_if: fetch push, execute resolve and predictor update bundle for br_resolve_queue
interface br_resolve_queue_if #(parameter int PC_WIDTH = 32, parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                i_push_vld;
  logic                o_push_rdy;
  logic [PC_WIDTH-1:0] i_push_pc;
  logic [PC_WIDTH-1:0] i_push_next_pc;
  logic                i_push_hit;
  logic                i_push_taken;
  logic                i_push_glb_taken;
  logic                i_push_loc_taken;
  logic                i_res_vld;
  logic                i_res_is_br;
  logic                i_res_taken;
  logic [PC_WIDTH-1:0] i_res_target;
  logic                o_redirect_vld;
  logic [PC_WIDTH-1:0] o_redirect_pc;
  logic                o_upd_btb_vld;
  logic [PC_WIDTH-1:0] o_upd_btb_pc;
  logic [PC_WIDTH-1:0] o_upd_btb_br_addr;
  logic                o_upd_pht_vld;
  logic                o_upd_eval_vld;
  logic                o_upd_pht_taken;
  logic                o_upd_pht_pred_glb_taken;
  logic                o_upd_pht_pred_loc_taken;
  logic [PC_WIDTH-1:0] o_upd_pht_pc;
  logic [CW-1:0]       o_count;
  logic                o_underflow;
  modport master (
    output i_push_vld, i_push_pc, i_push_next_pc, i_push_hit, i_push_taken, i_push_glb_taken, i_push_loc_taken,
    output i_res_vld, i_res_is_br, i_res_taken, i_res_target,
    input  o_push_rdy, o_redirect_vld, o_redirect_pc, o_upd_btb_vld, o_upd_btb_pc, o_upd_btb_br_addr,
    input  o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken,
    input  o_upd_pht_pc, o_count, o_underflow
  );
  modport slave (
    input  i_push_vld, i_push_pc, i_push_next_pc, i_push_hit, i_push_taken, i_push_glb_taken, i_push_loc_taken,
    input  i_res_vld, i_res_is_br, i_res_taken, i_res_target,
    output o_push_rdy, o_redirect_vld, o_redirect_pc, o_upd_btb_vld, o_upd_btb_pc, o_upd_btb_br_addr,
    output o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken,
    output o_upd_pht_pc, o_count, o_underflow
  );
endinterface

// File: rtl/br_resolve_queue.sv
// br_resolve_queue: in-flight prediction FIFO that checks resolves and issues redirect/predictor updates
module br_resolve_queue #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  br_resolve_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] npc;
    logic                hit;
    logic                tk;
    logic                glb;
    logic                loc;
  } ent_t;
  ent_t                r_mem [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_count;
  logic                r_redir_vld, r_btb_vld, r_pht_vld, r_eval_vld, r_pht_tk, r_pht_glb, r_pht_loc, r_uf;
  logic [PC_WIDTH-1:0] r_redir_pc, r_btb_pc, r_btb_addr, r_pht_pc;
  ent_t                w_head;
  logic                w_full, w_push, w_pop, w_act, w_tgt_diff, w_misp;
  logic [PC_WIDTH-1:0] w_corr;
  assign w_head     = r_mem[r_rp];
  assign w_full     = r_count == CW'(DEPTH);
  assign w_push     = bus.i_push_vld & ~w_full;
  assign w_pop      = bus.i_res_vld & (r_count != '0);
  assign w_act      = bus.i_res_is_br & bus.i_res_taken;
  assign w_tgt_diff = w_head.npc != bus.i_res_target;
  assign w_misp     = (w_head.tk != w_act) | (w_head.tk & w_act & w_tgt_diff);
  assign w_corr     = w_act ? bus.i_res_target : w_head.pc + PC_WIDTH'(4);
  // a push landing in the same cycle as a flush writes a slot the reset pointers never read
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= '{bus.i_push_pc, bus.i_push_next_pc, bus.i_push_hit,
                                 bus.i_push_taken, bus.i_push_glb_taken, bus.i_push_loc_taken};
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
      r_btb_vld   <= 1'b0;
      r_btb_pc    <= '0;
      r_btb_addr  <= '0;
      r_pht_vld   <= 1'b0;
      r_eval_vld  <= 1'b0;
      r_pht_tk    <= 1'b0;
      r_pht_glb   <= 1'b0;
      r_pht_loc   <= 1'b0;
      r_pht_pc    <= '0;
      r_uf        <= 1'b0;
    end else begin
      if (w_pop & w_misp) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_count <= '0;
      end else begin
        r_wp    <= w_push ? r_wp + AW'(1) : r_wp;
        r_rp    <= w_pop ? r_rp + AW'(1) : r_rp;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      r_redir_vld <= w_pop & w_misp;
      if (w_pop & w_misp) r_redir_pc <= w_corr;
      r_pht_vld  <= w_pop & bus.i_res_is_br;
      r_eval_vld <= w_pop & bus.i_res_is_br & w_head.hit;
      r_btb_vld  <= w_pop & w_act & (~w_head.hit | w_tgt_diff);
      if (w_pop) begin
        r_pht_pc   <= w_head.pc;
        r_pht_tk   <= bus.i_res_taken;
        r_pht_glb  <= w_head.glb;
        r_pht_loc  <= w_head.loc;
        r_btb_pc   <= w_head.pc;
        r_btb_addr <= bus.i_res_target;
      end
      r_uf <= r_uf | (bus.i_res_vld & (r_count == '0));
    end
  end
  assign bus.o_push_rdy               = ~w_full;
  assign bus.o_count                  = r_count;
  assign bus.o_underflow              = r_uf;
  assign bus.o_redirect_vld           = r_redir_vld;
  assign bus.o_redirect_pc            = r_redir_pc;
  assign bus.o_upd_btb_vld            = r_btb_vld;
  assign bus.o_upd_btb_pc             = r_btb_pc;
  assign bus.o_upd_btb_br_addr        = r_btb_addr;
  assign bus.o_upd_pht_vld            = r_pht_vld;
  assign bus.o_upd_eval_vld           = r_eval_vld;
  assign bus.o_upd_pht_taken          = r_pht_tk;
  assign bus.o_upd_pht_pred_glb_taken = r_pht_glb;
  assign bus.o_upd_pht_pred_loc_taken = r_pht_loc;
  assign bus.o_upd_pht_pc             = r_pht_pc;
endmodule
